id_ex_stage: RTL and testbench

//   ID/EX pipeline register for the 32-bit RISC-V core; sits directly downstream of the register file.

---
 rtl/proc_pkg.sv | 19 +
 rtl/id_ex_stage_load_use_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the RISC-V core pipeline: default widths and the
// bit map of the decode control bundle.
package proc_pkg;

    localparam int N_DEFAULT  = 32;
    localparam int M_DEFAULT  = 5;
    localparam int CW_DEFAULT = 8;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_ALUOP_LO = 5;
    localparam int CTRL_ALUOP_HI = 7;

    localparam logic [31:0] STALL_COUNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register a
// load currently in EX has not yet fetched from memory.
module load_use_detect
    import proc_pkg::*;
#(
    parameter int M = M_DEFAULT
) (
    input  logic         id_valid,
    input  logic [M-1:0] id_rs1,
    input  logic [M-1:0] id_rs2,
    input  logic         ex_valid,
    input  logic         ex_memread,
    input  logic [M-1:0] ex_rd,
    input  logic         flush,
    output logic         stall
);

    logic rd_nonzero_s;
    logic rs_match_s;

    // A redirect kills the dependent instruction anyway, so flush suppresses the stall.
    always_comb begin
        rd_nonzero_s = (ex_rd != {M{1'b0}});
        rs_match_s   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
        stall        = id_valid & ex_valid & ex_memread & rd_nonzero_s & rs_match_s & ~flush;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle writeback bypass, load-use bubble
// insertion and a saturating count of inserted bubbles.
module id_ex_stage
    import proc_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int M  = M_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [M-1:0]  id_rs1,
    input  logic [M-1:0]  id_rs2,
    input  logic [M-1:0]  id_rd,
    input  logic [N-1:0]  id_rdata1,
    input  logic [N-1:0]  id_rdata2,
    input  logic [N-1:0]  id_imm,
    input  logic [CW-1:0] id_ctrl,
    input  logic          wb_regwrite,
    input  logic [M-1:0]  wb_rd,
    input  logic [N-1:0]  wb_data,
    input  logic          flush,
    output logic          stall,
    output logic          ex_valid,
    output logic [M-1:0]  ex_rs1,
    output logic [M-1:0]  ex_rs2,
    output logic [M-1:0]  ex_rd,
    output logic [N-1:0]  ex_op1,
    output logic [N-1:0]  ex_op2,
    output logic [N-1:0]  ex_imm,
    output logic [CW-1:0] ex_ctrl,
    output logic [31:0]   stall_count
);

    logic          valid_q,  valid_d;
    logic [M-1:0]  rs1_q,    rs1_d;
    logic [M-1:0]  rs2_q,    rs2_d;
    logic [M-1:0]  rd_q,     rd_d;
    logic [N-1:0]  op1_q,    op1_d;
    logic [N-1:0]  op2_q,    op2_d;
    logic [N-1:0]  imm_q,    imm_d;
    logic [CW-1:0] ctrl_q,   ctrl_d;
    logic [31:0]   count_q,  count_d;

    logic          stall_raw_s;
    logic          wb_live_s;
    logic [N-1:0]  byp1_s;
    logic [N-1:0]  byp2_s;

    load_use_detect #(.M(M)) u_load_use_detect (
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_valid   (valid_q),
        .ex_memread (ctrl_q[CTRL_MEMREAD]),
        .ex_rd      (rd_q),
        .flush      (flush),
        .stall      (stall_raw_s)
    );

    // Stall is held low while reset is asserted even though EX is already empty.
    assign stall = stall_raw_s & reset;

    // The regfile write lands only on the edge, so forward WB data here; x0 is never bypassed.
    always_comb begin
        wb_live_s = wb_regwrite && (wb_rd != {M{1'b0}});
        if (wb_live_s && (wb_rd == id_rs1)) begin
            byp1_s = wb_data;
        end else begin
            byp1_s = id_rdata1;
        end
        if (wb_live_s && (wb_rd == id_rs2)) begin
            byp2_s = wb_data;
        end else begin
            byp2_s = id_rdata2;
        end
    end

    // Next state: flush beats stall beats a normal load; bubbles carry all-zero fields.
    always_comb begin
        valid_d = 1'b0;
        rs1_d   = {M{1'b0}};
        rs2_d   = {M{1'b0}};
        rd_d    = {M{1'b0}};
        op1_d   = {N{1'b0}};
        op2_d   = {N{1'b0}};
        imm_d   = {N{1'b0}};
        ctrl_d  = {CW{1'b0}};
        count_d = count_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (stall_raw_s) begin
            if (count_q != STALL_COUNT_MAX) begin
                count_d = count_q + 32'd1;
            end else begin
                count_d = count_q;
            end
        end else begin
            valid_d = id_valid;
            rs1_d   = id_rs1;
            rs2_d   = id_rs2;
            rd_d    = id_rd;
            op1_d   = byp1_s;
            op2_d   = byp2_s;
            imm_d   = id_imm;
            ctrl_d  = id_valid ? id_ctrl : {CW{1'b0}};
        end
    end

    // Pipeline register and bubble counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rs1_q   <= {M{1'b0}};
            rs2_q   <= {M{1'b0}};
            rd_q    <= {M{1'b0}};
            op1_q   <= {N{1'b0}};
            op2_q   <= {N{1'b0}};
            imm_q   <= {N{1'b0}};
            ctrl_q  <= {CW{1'b0}};
            count_q <= 32'd0;
        end else begin
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_op1      = op1_q;
    assign ex_op2      = op2_q;
    assign ex_imm      = imm_q;
    assign ex_ctrl     = ctrl_q;
    assign stall_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, capture, WB bypass,
// load-use stall, flush priority, non-hazards and async reset mid-stall.
module tb_id_ex_stage;

    localparam int N  = 32;
    localparam int M  = 5;
    localparam int CW = 8;

    logic          clock;
    logic          reset;
    logic          id_valid;
    logic [M-1:0]  id_rs1, id_rs2, id_rd;
    logic [N-1:0]  id_rdata1, id_rdata2, id_imm;
    logic [CW-1:0] id_ctrl;
    logic          wb_regwrite;
    logic [M-1:0]  wb_rd;
    logic [N-1:0]  wb_data;
    logic          flush;
    logic          stall;
    logic          ex_valid;
    logic [M-1:0]  ex_rs1, ex_rs2, ex_rd;
    logic [N-1:0]  ex_op1, ex_op2, ex_imm;
    logic [CW-1:0] ex_ctrl;
    logic [31:0]   stall_count;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.N(N), .M(M), .CW(CW)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_ctrl(ex_ctrl), .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive_id(input logic v, input logic [M-1:0] rs1, input logic [M-1:0] rs2,
                            input logic [M-1:0] rd, input logic [N-1:0] d1, input logic [N-1:0] d2,
                            input logic [N-1:0] imm, input logic [CW-1:0] ctrl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; id_ctrl = ctrl;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; flush = 1'b0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 8'h00);
        step(); step();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0b want=0", ex_valid); end
        total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", stall_count); end
        total++; if ({ex_op1, ex_op2, ex_imm, ex_ctrl} !== 104'd0) begin bad++; $display("FAIL reset_fields op1=%h op2=%h imm=%h ctrl=%h want=0", ex_op1, ex_op2, ex_imm, ex_ctrl); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_capture;
        drive_id(1'b1, 5'd3, 5'd2, 5'd4, 32'h11, 32'h22, 32'h123, 8'h11);
        step();
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL cap_valid got=%0b want=1", ex_valid); end
        total++; if (ex_op1 !== 32'h11) begin bad++; $display("FAIL cap_op1 got=%h want=00000011", ex_op1); end
        total++; if ({ex_rs1, ex_rs2, ex_rd} !== {5'd3, 5'd2, 5'd4}) begin bad++; $display("FAIL cap_idx got=%0d/%0d/%0d want=3/2/4", ex_rs1, ex_rs2, ex_rd); end
        total++; if ({ex_op2, ex_imm, ex_ctrl} !== {32'h22, 32'h123, 8'h11}) begin bad++; $display("FAIL cap_fields op2=%h imm=%h ctrl=%h want=22/123/11", ex_op2, ex_imm, ex_ctrl); end
        // invalid ID: EX gets ex_valid=0 and zero control even though id_ctrl is nonzero
        drive_id(1'b0, 5'd1, 5'd1, 5'd9, 32'h5, 32'h6, 32'h7, 8'hFF);
        step();
        total++; if ({ex_valid, ex_ctrl} !== 9'd0) begin bad++; $display("FAIL cap_invalid valid=%0b ctrl=%h want=0/00", ex_valid, ex_ctrl); end
    endtask

    task automatic test_bypass;
        wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFE;
        drive_id(1'b1, 5'd5, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, 8'h01);
        step();
        total++; if (ex_op2 !== 32'hCAFE) begin bad++; $display("FAIL byp_op2 got=%h want=0000cafe", ex_op2); end
        total++; if (ex_op1 !== 32'hCAFE) begin bad++; $display("FAIL byp_op1 got=%h want=0000cafe", ex_op1); end
        wb_rd = 5'd0;
        drive_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h66, 32'h77, 32'h0, 8'h01);
        step();
        total++; if (ex_op2 !== 32'h77) begin bad++; $display("FAIL byp_x0_op2 got=%h want=00000077", ex_op2); end
        wb_regwrite = 1'b0; wb_rd = 5'd5;
        drive_id(1'b1, 5'd5, 5'd4, 5'd6, 32'h88, 32'h99, 32'h0, 8'h01);
        step();
        total++; if (ex_op1 !== 32'h88) begin bad++; $display("FAIL byp_nowrite_op1 got=%h want=00000088", ex_op1); end
        wb_rd = 5'd0; wb_data = 32'd0;
    endtask

    task automatic test_load_use;
        drive_id(1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 8'h03);
        step();
        drive_id(1'b1, 5'd7, 5'd2, 5'd8, 32'hA, 32'hB, 32'h0, 8'h01);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b want=1", stall); end
        step();
        total++; if ({ex_valid, ex_ctrl} !== 9'd0) begin bad++; $display("FAIL lu_bubble valid=%0b ctrl=%h want=0/00", ex_valid, ex_ctrl); end
        total++; if (stall_count !== 32'd1) begin bad++; $display("FAIL lu_count got=%0d want=1", stall_count); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_drop got=%0b want=0", stall); end
        step();
        total++; if ({ex_valid, ex_rd, ex_ctrl, ex_op1} !== {1'b1, 5'd8, 8'h01, 32'hA}) begin bad++; $display("FAIL lu_add valid=%0b rd=%0d ctrl=%h op1=%h want=1/8/01/0000000a", ex_valid, ex_rd, ex_ctrl, ex_op1); end
    endtask

    task automatic test_flush_stall;
        drive_id(1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 8'h03);
        step();
        drive_id(1'b1, 5'd7, 5'd2, 5'd8, 32'hA, 32'hB, 32'h0, 8'h01);
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fs_stall got=%0b want=0", stall); end
        step();
        total++; if ({ex_valid, ex_ctrl} !== 9'd0) begin bad++; $display("FAIL fs_bubble valid=%0b ctrl=%h want=0/00", ex_valid, ex_ctrl); end
        total++; if (stall_count !== 32'd1) begin bad++; $display("FAIL fs_count got=%0d want=1", stall_count); end
        flush = 1'b0;
    endtask

    task automatic test_no_hazard;
        drive_id(1'b1, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 8'h03);
        step();
        drive_id(1'b1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 8'h01);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL nh_rd0 got=%0b want=0", stall); end
        drive_id(1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 8'h01);
        step();
        drive_id(1'b1, 5'd3, 5'd7, 5'd8, 32'h0, 32'h0, 32'h0, 8'h01);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL nh_nomemread got=%0b want=0", stall); end
        drive_id(1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 8'h03);
        step();
        drive_id(1'b0, 5'd7, 5'd7, 5'd8, 32'h0, 32'h0, 32'h0, 8'h01);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL nh_idinvalid got=%0b want=0", stall); end
    endtask

    task automatic test_reset_mid_stall;
        drive_id(1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0, 8'h03);
        step();
        drive_id(1'b1, 5'd3, 5'd7, 5'd8, 32'h0, 32'h0, 32'h0, 8'h01);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rms_stall_rs2 got=%0b want=1", stall); end
        total++; if (stall_count !== 32'd1) begin bad++; $display("FAIL rms_count_before got=%0d want=1", stall_count); end
        reset = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rms_stall got=%0b want=0", stall); end
        total++; if ({ex_valid, stall_count} !== 33'd0) begin bad++; $display("FAIL rms_state valid=%0b count=%0d want=0/0", ex_valid, stall_count); end
        @(negedge clock);
        reset = 1'b1;
        step();
        total++; if ({ex_valid, ex_rd, stall_count} !== {1'b1, 5'd8, 32'd0}) begin bad++; $display("FAIL rms_restart valid=%0b rd=%0d count=%0d want=1/8/0", ex_valid, ex_rd, stall_count); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_bypass();
        test_load_use();
        test_flush_stall();
        test_no_hazard();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
